// File: rtl/push_pop_sequencer_pkg.sv
// Shared definitions for the PUSH/POP multi-register transfer sequencer:
// FSM encoding, special register indices and the register-list width.
package push_pop_sequencer_pkg;

    localparam int         LIST_W = 9;
    localparam logic [3:0] SP_I   = 4'hD;
    localparam logic [3:0] LR_I   = 4'hE;
    localparam logic [3:0] PC_I   = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_WB    = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    // Number of registers selected by the 9-bit list (0..9).
    function automatic logic [3:0] list_popcount(input logic [LIST_W-1:0] list);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < LIST_W; i++) begin
            n = n + {3'd0, list[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/push_pop_sequencer_priority_index.sv
// Lowest-set-bit finder over the remaining register list; bit 0 (R0) wins.
module priority_index
    import push_pop_sequencer_pkg::*;
(
    input  logic [LIST_W-1:0] i_list,
    output logic [3:0]        o_idx,
    output logic              o_valid
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        o_idx   = 4'd0;
        o_valid = 1'b0;
        for (int i = LIST_W - 1; i >= 0; i--) begin
            if (i_list[i]) begin
                o_idx   = 4'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/push_pop_sequencer.sv
// Multi-register PUSH/POP sequencer: walks the selected registers in ascending
// order, moving each through a single-beat memory handshake, then updates SP.
module push_pop_sequencer
    import push_pop_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_pop,
    input  logic [7:0]  reg_list,
    input  logic        m_bit,
    input  logic [31:0] sp_in,
    output logic [3:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        ld_rd,
    output logic [3:0]  addr_rd,
    output logic [31:0] w_rd,
    output logic        ld_sp,
    output logic [31:0] w_sp,
    output logic        ld_pc,
    output logic [31:0] w_pc,
    output logic        busy,
    output logic        done,
    output logic        fault
);

    state_t              r_state;
    logic                r_is_pop;
    logic [LIST_W-1:0]   r_list;
    logic [31:0]         r_sp;
    logic [31:0]         r_base;
    logic [3:0]          r_count;

    logic                r_mem_req;
    logic                r_mem_we;
    logic [31:0]         r_mem_addr;
    logic                r_ld_rd;
    logic [3:0]          r_addr_rd;
    logic [31:0]         r_w_rd;
    logic                r_ld_sp;
    logic [31:0]         r_w_sp;
    logic                r_ld_pc;
    logic [31:0]         r_w_pc;
    logic                r_done;
    logic                r_fault;

    logic [3:0]          w_pos;
    logic                w_valid;
    logic [3:0]          w_reg_idx;
    logic [LIST_W-1:0]   w_onehot;
    logic [LIST_W-1:0]   w_rest;
    logic [3:0]          w_setup_cnt;
    logic [31:0]         w_setup_span;
    logic [31:0]         w_setup_base;
    logic [31:0]         w_pop_sp;
    logic                w_push_xfer;

    priority_index u_priority_index (
        .i_list  (r_list),
        .o_idx   (w_pos),
        .o_valid (w_valid)
    );

    // List slot 8 is LR when pushing and PC when popping.
    assign w_reg_idx    = (w_pos == 4'd8) ? (r_is_pop ? PC_I : LR_I) : w_pos;
    assign w_onehot     = {{(LIST_W-1){1'b0}}, 1'b1} << w_pos;
    assign w_rest       = r_list & ~w_onehot;
    assign w_setup_cnt  = list_popcount(r_list);
    assign w_setup_span = {26'd0, w_setup_cnt, 2'b00};
    assign w_setup_base = r_is_pop ? r_sp : (r_sp - w_setup_span);
    assign w_pop_sp     = r_sp + {26'd0, r_count, 2'b00};

    // Push data comes straight off the combinational register-file read port,
    // so it is held for as long as the index is held in XFER.
    assign w_push_xfer = (r_state == ST_XFER) && !r_is_pop && w_valid;
    assign rd_addr     = w_push_xfer ? w_reg_idx : 4'h0;
    assign mem_wdata   = w_push_xfer ? rd_data : 32'h0;

    assign busy      = (r_state != ST_IDLE);
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign ld_rd     = r_ld_rd;
    assign addr_rd   = r_addr_rd;
    assign w_rd      = r_w_rd;
    assign ld_sp     = r_ld_sp;
    assign w_sp      = r_w_sp;
    assign ld_pc     = r_ld_pc;
    assign w_pc      = r_w_pc;
    assign done      = r_done;
    assign fault     = r_fault;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_is_pop   <= 1'b0;
            r_list     <= '0;
            r_sp       <= 32'h0;
            r_base     <= 32'h0;
            r_count    <= 4'd0;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= 32'h0;
            r_ld_rd    <= 1'b0;
            r_addr_rd  <= 4'h0;
            r_w_rd     <= 32'h0;
            r_ld_sp    <= 1'b0;
            r_w_sp     <= 32'h0;
            r_ld_pc    <= 1'b0;
            r_w_pc     <= 32'h0;
            r_done     <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_fault <= 1'b0;
            r_ld_rd <= 1'b0;
            r_ld_pc <= 1'b0;
            r_ld_sp <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_is_pop <= is_pop;
                        r_list   <= {m_bit, reg_list};
                        r_sp     <= sp_in;
                        r_state  <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    r_count <= w_setup_cnt;
                    r_base  <= w_setup_base;
                    if (w_setup_cnt == 4'd0) begin
                        r_done  <= 1'b1;
                        r_fault <= 1'b1;
                        r_state <= ST_FIN;
                    end else begin
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= ~r_is_pop;
                        r_mem_addr <= w_setup_base;
                        r_state    <= ST_XFER;
                    end
                end

                ST_XFER: begin
                    if (mem_ack) begin
                        r_list <= w_rest;
                        if (r_is_pop) begin
                            r_mem_req <= 1'b0;
                            r_mem_we  <= 1'b0;
                            if (w_pos == 4'd8) begin
                                r_ld_pc <= 1'b1;
                                r_w_pc  <= mem_rdata & 32'hFFFF_FFFE;
                            end else begin
                                r_ld_rd   <= 1'b1;
                                r_addr_rd <= w_reg_idx;
                                r_w_rd    <= mem_rdata;
                            end
                            r_state <= ST_WB;
                        end else if (w_rest == '0) begin
                            r_mem_req  <= 1'b0;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= 32'h0;
                            r_done     <= 1'b1;
                            r_ld_sp    <= 1'b1;
                            r_w_sp     <= r_base;
                            r_state    <= ST_FIN;
                        end else begin
                            r_mem_addr <= r_mem_addr + 32'd4;
                        end
                    end
                end

                // The popped bit was already cleared on the ack, so an empty
                // list here means the write-back just issued was the last one.
                ST_WB: begin
                    if (r_list == '0) begin
                        r_mem_addr <= 32'h0;
                        r_done     <= 1'b1;
                        r_ld_sp    <= 1'b1;
                        r_w_sp     <= w_pop_sp;
                        r_state    <= ST_FIN;
                    end else begin
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= r_mem_addr + 32'd4;
                        r_state    <= ST_XFER;
                    end
                end

                ST_FIN: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_push_pop_sequencer.sv
// Self-checking bench for push_pop_sequencer: directed scenarios plus random
// PUSH/POP operations compared against a list-level reference model.
module tb_push_pop_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_pop;
    logic [7:0]  reg_list;
    logic        m_bit;
    logic [31:0] sp_in;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        ld_rd;
    logic [3:0]  addr_rd;
    logic [31:0] w_rd;
    logic        ld_sp;
    logic [31:0] w_sp;
    logic        ld_pc;
    logic [31:0] w_pc;
    logic        busy;
    logic        done;
    logic        fault;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    push_pop_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_pop    (is_pop),
        .reg_list  (reg_list),
        .m_bit     (m_bit),
        .sp_in     (sp_in),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .ld_rd     (ld_rd),
        .addr_rd   (addr_rd),
        .w_rd      (w_rd),
        .ld_sp     (ld_sp),
        .w_sp      (w_sp),
        .ld_pc     (ld_pc),
        .w_pc      (w_pc),
        .busy      (busy),
        .done      (done),
        .fault     (fault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file and memory models
    logic [31:0] rf [16];
    logic [31:0] mem [logic [31:0]];
    assign rd_data = rf[rd_addr];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_C3C3);
    endfunction

    // Observation logs filled by the monitor
    logic [31:0] q_addr[$];
    logic [31:0] q_wd[$];
    logic        q_we[$];
    int          q_kind[$];
    logic [3:0]  q_lda[$];
    logic [31:0] q_ldd[$];
    int done_cnt, done_at, fault_cnt, fault_at, sp_at;
    bit unstable, multi_ld;

    int g_delay = 0;
    bit g_rand_delay = 1'b0;
    bit g_spur = 1'b0;

    bit          pend = 1'b0;
    logic [31:0] p_addr, p_wd;
    int          wait_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            mem_ack = 1'b0;
            pend    = 1'b0;
        end else begin
            if (done)  begin done_cnt++;  done_at  = cyc; end
            if (fault) begin fault_cnt++; fault_at = cyc; end
            if (int'(ld_rd) + int'(ld_pc) + int'(ld_sp) > 1) multi_ld = 1'b1;
            if (ld_rd) begin q_kind.push_back(0); q_lda.push_back(addr_rd); q_ldd.push_back(w_rd); end
            if (ld_pc) begin q_kind.push_back(1); q_lda.push_back(4'h0);    q_ldd.push_back(w_pc); end
            if (ld_sp) begin q_kind.push_back(2); q_lda.push_back(4'h0);    q_ldd.push_back(w_sp); sp_at = cyc; end
            if (mem_req) begin
                if (!pend) begin
                    pend     = 1'b1;
                    p_addr   = mem_addr;
                    p_wd     = mem_wdata;
                    wait_cnt = g_rand_delay ? int'($urandom_range(0, 3)) : g_delay;
                end else if (mem_addr !== p_addr || mem_wdata !== p_wd) begin
                    unstable = 1'b1;
                end
                if (wait_cnt == 0) begin
                    mem_ack = 1'b1;
                    pend    = 1'b0;
                    q_addr.push_back(mem_addr);
                    q_we.push_back(mem_we);
                    q_wd.push_back(mem_wdata);
                    mem_rdata = mem_rd(mem_addr);
                    if (mem_we) mem[mem_addr] = mem_wdata;
                end else begin
                    mem_ack   = 1'b0;
                    wait_cnt--;
                    mem_rdata = $urandom;
                end
            end else begin
                pend      = 1'b0;
                mem_ack   = g_spur ? 1'($urandom_range(0, 1)) : 1'b0;
                mem_rdata = $urandom;
            end
        end
    end

    task automatic clear_logs();
        q_addr.delete(); q_wd.delete(); q_we.delete();
        q_kind.delete(); q_lda.delete(); q_ldd.delete();
        done_cnt = 0; done_at = 0; fault_cnt = 0; fault_at = 0; sp_at = 0;
        unstable = 1'b0; multi_ld = 1'b0;
    endtask

    task automatic randomize_rf();
        for (int i = 0; i < 16; i++) rf[i] = $urandom;
    endtask

    // Runs one operation and checks it against the list-level model.
    task automatic do_op(input bit pop, input logic [8:0] list, input logic [31:0] sp,
                         input int inject_at, output int lat);
        logic [31:0] e_addr[$];
        logic [31:0] e_wd[$];
        int          e_kind[$];
        logic [3:0]  e_lda[$];
        logic [31:0] e_ldd[$];
        int          cnt, k, c0, exp_lat;
        logic [31:0] base, a;
        logic [3:0]  idx;
        bit          fixed_ack;

        cnt = 0;
        for (int i = 0; i < 9; i++) if (list[i]) cnt++;
        base = pop ? sp : sp - 32'(cnt * 4);
        k = 0;
        for (int i = 0; i < 9; i++) begin
            if (list[i]) begin
                idx = (i < 8) ? 4'(i) : (pop ? 4'hF : 4'hE);
                a   = base + 32'(4 * k);
                e_addr.push_back(a);
                e_wd.push_back(rf[idx]);
                if (pop && i == 8) begin
                    e_kind.push_back(1); e_lda.push_back(4'h0); e_ldd.push_back(mem_rd(a) & 32'hFFFF_FFFE);
                end else if (pop) begin
                    e_kind.push_back(0); e_lda.push_back(idx); e_ldd.push_back(mem_rd(a));
                end
                k++;
            end
        end
        if (cnt > 0) begin
            e_kind.push_back(2); e_lda.push_back(4'h0);
            e_ldd.push_back(pop ? sp + 32'(4 * cnt) : base);
        end
        exp_lat   = pop ? 2 + 2 * cnt : 2 + cnt;
        fixed_ack = !g_rand_delay && g_delay == 0;

        clear_logs();
        start = 1'b1; is_pop = pop; reg_list = list[7:0]; m_bit = list[8]; sp_in = sp;
        c0 = cyc;
        @(negedge clk); #1;
        start = 1'b0; is_pop = 1'($urandom); reg_list = 8'($urandom); m_bit = 1'($urandom); sp_in = $urandom;
        for (int t = 1; t <= 400; t++) begin
            if (t == 1) begin
                vectors++;
                if (busy !== 1'b1) begin miscompares++; $display("FAIL busy_in_op: got %b, want 1", busy); end
            end
            if (done_cnt > 0) break;
            start = (t == inject_at);
            if (start) begin is_pop = ~pop; reg_list = 8'h01; m_bit = 1'b1; sp_in = 32'h1234_5670; end
            @(negedge clk); #1;
        end
        start = 1'b0;
        lat = done_at - c0;
        repeat (3) @(negedge clk);
        #1;

        vectors++;
        if (done_cnt != 1) begin miscompares++; $display("FAIL done_pulses: got %0d, want 1", done_cnt); end
        vectors++;
        if (q_addr.size() != e_addr.size()) begin
            miscompares++; $display("FAIL xfer_count: got %0d, want %0d", q_addr.size(), e_addr.size());
        end
        for (int i = 0; i < e_addr.size() && i < q_addr.size(); i++) begin
            vectors++;
            if (q_addr[i] !== e_addr[i]) begin miscompares++; $display("FAIL xfer_addr[%0d]: got %h, want %h", i, q_addr[i], e_addr[i]); end
            vectors++;
            if (q_we[i] !== !pop) begin miscompares++; $display("FAIL xfer_we[%0d]: got %b, want %b", i, q_we[i], !pop); end
            if (!pop) begin
                vectors++;
                if (q_wd[i] !== e_wd[i]) begin miscompares++; $display("FAIL xfer_wdata[%0d]: got %h, want %h", i, q_wd[i], e_wd[i]); end
            end
        end
        vectors++;
        if (q_kind.size() != e_kind.size()) begin
            miscompares++; $display("FAIL ld_count: got %0d, want %0d", q_kind.size(), e_kind.size());
        end
        for (int i = 0; i < e_kind.size() && i < q_kind.size(); i++) begin
            vectors++;
            if (q_kind[i] != e_kind[i] || q_lda[i] !== e_lda[i] || q_ldd[i] !== e_ldd[i]) begin
                miscompares++;
                $display("FAIL ld[%0d]: got kind %0d addr %h data %h, want kind %0d addr %h data %h",
                         i, q_kind[i], q_lda[i], q_ldd[i], e_kind[i], e_lda[i], e_ldd[i]);
            end
        end
        vectors++;
        if (fault_cnt != ((cnt == 0) ? 1 : 0)) begin
            miscompares++; $display("FAIL fault_pulses: got %0d, want %0d", fault_cnt, (cnt == 0) ? 1 : 0);
        end
        if (cnt == 0) begin
            vectors++;
            if (fault_at != done_at) begin miscompares++; $display("FAIL fault_cycle: got %0d, want %0d", fault_at, done_at); end
        end else begin
            vectors++;
            if (sp_at != done_at) begin miscompares++; $display("FAIL ld_sp_cycle: got %0d, want %0d", sp_at, done_at); end
        end
        if (fixed_ack) begin
            vectors++;
            if (lat != exp_lat) begin miscompares++; $display("FAIL latency: got %0d, want %0d", lat, exp_lat); end
        end
        vectors++;
        if (unstable) begin miscompares++; $display("FAIL mem_stable: got changing addr/wdata, want stable"); end
        vectors++;
        if (multi_ld) begin miscompares++; $display("FAIL one_ld_per_cycle: got overlap, want none"); end
        vectors++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            miscompares++; $display("FAIL idle_after: got busy %b mem_req %b, want 0 0", busy, mem_req);
        end
    endtask

    task automatic test_reset();
        logic [31:0] outs [13];
        outs = '{32'(rd_addr), 32'(mem_req), 32'(mem_we), mem_addr, mem_wdata, 32'(ld_rd),
                 32'(addr_rd), w_rd, 32'(ld_sp), w_sp, 32'(ld_pc), w_pc, 32'({busy, done, fault})};
        for (int i = 0; i < 13; i++) begin
            vectors++;
            if (outs[i] !== 32'h0) begin miscompares++; $display("FAIL reset_out[%0d]: got %h, want 0", i, outs[i]); end
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            miscompares++; $display("FAIL post_reset_idle: got busy %b mem_req %b, want 0 0", busy, mem_req);
        end
    endtask

    task automatic test_push_basic();
        int lat;
        randomize_rf();
        g_delay = 0; g_rand_delay = 1'b0; g_spur = 1'b0;
        do_op(1'b0, 9'h103, 32'h2000_0100, 0, lat);
        vectors++;
        if (q_addr.size() != 3 || q_addr[0] !== 32'h2000_00F4 || q_wd[2] !== rf[14]) begin
            miscompares++; $display("FAIL push_basic_first: got %h, want 2000_00F4", (q_addr.size() > 0) ? q_addr[0] : 32'h0);
        end
        vectors++;
        if (q_ldd.size() != 1 || q_ldd[0] !== 32'h2000_00F4) begin
            miscompares++; $display("FAIL push_basic_sp: got %h, want 2000_00F4", (q_ldd.size() > 0) ? q_ldd[0] : 32'h0);
        end
        vectors++;
        if (lat != 5) begin miscompares++; $display("FAIL push_basic_done_cycle: got %0d, want 5", lat); end
    endtask

    task automatic test_pop_basic();
        int lat;
        randomize_rf();
        mem[32'h2000_00F8] = 32'h0000_0011;
        mem[32'h2000_00FC] = 32'h0800_0043;
        do_op(1'b1, 9'h104, 32'h2000_00F8, 0, lat);
        vectors++;
        if (q_kind.size() != 3 || q_kind[0] != 0 || q_lda[0] !== 4'h2 || q_ldd[0] !== 32'h11 ||
            q_kind[1] != 1 || q_ldd[1] !== 32'h0800_0042 || q_kind[2] != 2 || q_ldd[2] !== 32'h2000_0100) begin
            miscompares++; $display("FAIL pop_basic_writes: got %0d writes, want rd2=11 pc=08000042 sp=20000100", q_kind.size());
        end
    endtask

    task automatic test_empty();
        int lat;
        do_op(1'b0, 9'h000, $urandom, 0, lat);
        vectors++;
        if (q_addr.size() != 0 || q_kind.size() != 0) begin
            miscompares++; $display("FAIL empty_push_activity: got %0d xfers %0d lds, want 0 0", q_addr.size(), q_kind.size());
        end
        do_op(1'b1, 9'h000, $urandom, 0, lat);
        vectors++;
        if (fault_cnt != 1 || q_addr.size() != 0) begin
            miscompares++; $display("FAIL empty_pop: got fault %0d xfers %0d, want 1 0", fault_cnt, q_addr.size());
        end
    endtask

    task automatic test_delayed_ack();
        int lat;
        g_delay = 3; g_spur = 1'b1;
        randomize_rf();
        do_op(1'b0, 9'h1A5, 32'h1000_0040, 0, lat);
        vectors++;
        if (lat < 2 + 5 * 4) begin miscompares++; $display("FAIL delayed_push_latency: got %0d, want >= 22", lat); end
        randomize_rf();
        do_op(1'b1, 9'h1A5, 32'h1000_002C, 0, lat);
        g_delay = 0; g_spur = 1'b0;
    endtask

    task automatic test_reset_mid();
        int xf_at_rst;
        logic [31:0] sp;
        sp = 32'h3000_0000;
        mem[sp] = 32'hCAFE_0000; mem[sp + 4] = 32'hCAFE_0001; mem[sp + 8] = 32'hCAFE_0002;
        clear_logs();
        start = 1'b1; is_pop = 1'b1; reg_list = 8'h07; m_bit = 1'b0; sp_in = sp;
        @(negedge clk); #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (mem_req !== 1'b1 || q_kind.size() != 1) begin
            miscompares++; $display("FAIL reset_mid_setup: got mem_req %b lds %0d, want 1 1", mem_req, q_kind.size());
        end
        xf_at_rst = q_addr.size();
        rst = 1'b1;
        #1;
        vectors++;
        if (busy !== 1'b0 || mem_req !== 1'b0 || ld_rd !== 1'b0) begin
            miscompares++; $display("FAIL reset_mid_immediate: got busy %b mem_req %b ld_rd %b, want 0 0 0", busy, mem_req, ld_rd);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        vectors++;
        if (q_kind.size() != 1 || q_kind[0] != 0 || q_lda[0] !== 4'h0 || q_ldd[0] !== 32'hCAFE_0000) begin
            miscompares++; $display("FAIL reset_mid_writes: got %0d writes, want only R0=cafe0000", q_kind.size());
        end
        vectors++;
        if (q_addr.size() != xf_at_rst || done_cnt != 0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL reset_mid_quiet: got xfers %0d done %0d busy %b, want %0d 0 0",
                                    q_addr.size(), done_cnt, busy, xf_at_rst);
        end
    endtask

    task automatic test_busy_start_wrap();
        int lat;
        randomize_rf();
        do_op(1'b0, 9'h0FF, 32'h0000_0004, 3, lat);
        vectors++;
        if (q_addr.size() != 8 || q_addr[0] !== 32'hFFFF_FFE4 || q_addr[7] !== 32'h0000_0000) begin
            miscompares++; $display("FAIL wrap_addrs: got first %h, want FFFF_FFE4", (q_addr.size() > 0) ? q_addr[0] : 32'h0);
        end
        vectors++;
        if (q_ldd.size() != 1 || q_ldd[0] !== 32'hFFFF_FFE4) begin
            miscompares++; $display("FAIL wrap_sp: got %h, want FFFF_FFE4", (q_ldd.size() > 0) ? q_ldd[0] : 32'h0);
        end
    endtask

    task automatic test_random();
        int lat;
        logic [8:0] list;
        for (int n = 0; n < 40; n++) begin
            randomize_rf();
            g_rand_delay = (n % 3) != 0;
            g_spur       = (n % 2) == 1;
            list = ($urandom_range(0, 7) == 0) ? 9'h000 : 9'($urandom);
            do_op(1'($urandom), list, {$urandom} & 32'hFFFF_FFFC, 0, lat);
        end
        g_rand_delay = 1'b0; g_spur = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; is_pop = 1'b0; reg_list = 8'h00; m_bit = 1'b0; sp_in = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        for (int i = 0; i < 16; i++) rf[i] = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        test_reset();
        test_push_basic();
        test_pop_basic();
        test_empty();
        test_delayed_ack();
        test_reset_mid();
        test_busy_start_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
